// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared access-type and FSM state types for the dmem arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Encodings 3'd3, 3'd6 and 3'd7 are undefined and rejected at grant.
  typedef enum logic [2:0] {
    BYTE   = 3'd0,
    HALF   = 3'd1,
    WORD   = 3'd2,
    U_BYTE = 3'd4,
    U_HALF = 3'd5
  } load3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned c_num_ports = 2;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Requester-side request/response bundle for both arbiter ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) ();

  logic   [c_num_ports-1:0]                     req_i;
  logic   [c_num_ports-1:0][ADDRESS_WIDTH-1:0]  addr_i;
  logic   [c_num_ports-1:0][DATA_WIDTH*4-1:0]   wdata_i;
  load3_t [c_num_ports-1:0]                     load3_i;
  logic   [c_num_ports-1:0]                     we_i;
  logic   [c_num_ports-1:0]                     gnt_o;
  logic   [c_num_ports-1:0]                     rvalid_o;
  logic   [DATA_WIDTH*4-1:0]                    rdata_o;
  logic                                         err_o;
  logic   [c_num_ports-1:0]                     rready_i;

  modport slave (
    input  req_i, addr_i, wdata_i, load3_i, we_i, rready_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

  modport master (
    output req_i, addr_i, wdata_i, load3_i, we_i, rready_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/dmem_align_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_align_check
// Description : Flags misaligned accesses, unsigned stores and undefined types.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_align_check
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] i_addr_lsb,
  input  load3_t     i_load3,
  input  logic       i_we,
  output logic       o_err
);

  always_comb begin
    o_err = 1'b0;
    case (i_load3)
      BYTE:    o_err = 1'b0;
      HALF:    o_err = i_addr_lsb[0];
      WORD:    o_err = |i_addr_lsb;
      U_BYTE:  o_err = i_we;
      U_HALF:  o_err = i_we | i_addr_lsb[0];
      default: o_err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin two-port arbiter sequencing one data_mem access
//               per grant and returning a registered response to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  dmem_arbiter_if.slave            bus,
  output logic [ADDRESS_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH*4-1:0]  wd_o,
  output load3_t                   load3_o,
  output logic                     wen_o,
  input  logic [DATA_WIDTH*4-1:0]  rd_i
);

  state_t                    r_state;
  state_t                    w_state_next;
  logic                      r_last;
  logic                      r_owner;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH*4-1:0]   r_wdata;
  load3_t                    r_load3;
  logic                      r_we;
  logic                      r_err;
  logic [DATA_WIDTH*4-1:0]   r_rdata;

  logic                      w_win;
  logic                      w_grant;
  logic                      w_err;

  // On a tie the port that did not win last time goes first.
  assign w_win = (bus.req_i == 2'b11) ? ~r_last : bus.req_i[1];

  dmem_align_check u_align_check (
    .i_addr_lsb (bus.addr_i[w_win][1:0]),
    .i_load3    (bus.load3_i[w_win]),
    .i_we       (bus.we_i[w_win]),
    .o_err      (w_err)
  );

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    case (r_state)
      IDLE: begin
        if (|bus.req_i) begin
          w_grant          = 1'b1;
          bus.gnt_o[w_win] = 1'b1;
          w_state_next     = ACCESS;
        end
      end
      ACCESS: w_state_next = RESP;
      RESP: begin
        bus.rvalid_o[r_owner] = 1'b1;
        if (bus.rready_i[r_owner]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_load3 <= WORD;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_addr  <= bus.addr_i[w_win];
        r_wdata <= bus.wdata_i[w_win];
        r_load3 <= bus.load3_i[w_win];
        r_we    <= bus.we_i[w_win];
        r_err   <= w_err;
      end
      // rd_i settles from the address/type registers during ACCESS.
      if (r_state == ACCESS) r_rdata <= (r_we || r_err) ? '0 : rd_i;
    end
  end

  assign a_o         = r_addr;
  assign wd_o        = r_wdata;
  assign load3_o     = r_load3;
  assign wen_o       = (r_state == ACCESS) & r_we & ~r_err;
  assign bus.rdata_o = r_rdata;
  assign bus.err_o   = (r_state == RESP) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed and random bench for dmem_arbiter with a byte memory
//               and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] a;
  logic [31:0]   wd;
  logic [31:0]   rd;
  load3_t        t;
  logic          wen;

  dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .a_o     (a),
    .wd_o    (wd),
    .load3_o (t),
    .wen_o   (wen),
    .rd_i    (rd)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 73 + 5);
  endfunction

  function automatic logic [31:0] read_bytes(input logic [7:0] m [256], input logic [7:0] ad, input load3_t ty);
    logic [7:0] a1, a2, a3;
    a1 = ad + 8'd1;
    a2 = ad + 8'd2;
    a3 = ad + 8'd3;
    case (ty)
      BYTE:    return {{24{m[ad][7]}}, m[ad]};
      U_BYTE:  return {24'd0, m[ad]};
      HALF:    return {{16{m[a1][7]}}, m[a1], m[ad]};
      U_HALF:  return {16'd0, m[a1], m[ad]};
      default: return {m[a3], m[a2], m[a1], m[ad]};
    endcase
  endfunction

  // Environment memory standing in for data_mem.
  logic [7:0] mem [256];
  always_comb rd = read_bytes(mem, a, t);
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (wen) begin
      mem[a] <= wd[7:0];
      if (t == HALF || t == WORD) mem[a + 8'd1] <= wd[15:8];
      if (t == WORD) begin
        mem[a + 8'd2] <= wd[23:16];
        mem[a + 8'd3] <= wd[31:24];
      end
    end
  end

  // Reference model state.
  logic [7:0]  shadow [256];
  int          m_phase;          // 0 idle, 1 memory cycle, 2 response pending
  logic        m_last, m_owner, m_err, m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wd, m_rdata;
  load3_t      m_ty;

  logic [1:0]  s_req, s_rr, granted;
  logic [7:0]  s_addr [2];
  logic [31:0] s_wd [2];
  load3_t      s_ty [2];
  logic        s_we [2];
  logic [31:0] last_rdata;
  logic        last_err;
  int          gnt_log [$];

  function automatic logic spec_err(input logic [7:0] ad, input load3_t ty, input logic we);
    if (ty == HALF)   return ad[0];
    if (ty == WORD)   return ad[1:0] != 2'b00;
    if (ty == BYTE)   return 1'b0;
    if (ty == U_BYTE) return we;
    if (ty == U_HALF) return we || ad[0];
    return 1'b1;
  endfunction

  task automatic shadow_store(input logic [7:0] ad, input load3_t ty, input logic [31:0] d);
    logic [7:0] a1, a2, a3;
    a1 = ad + 8'd1;
    a2 = ad + 8'd2;
    a3 = ad + 8'd3;
    shadow[ad] = d[7:0];
    if (ty == HALF || ty == WORD) shadow[a1] = d[15:8];
    if (ty == WORD) begin
      shadow[a2] = d[23:16];
      shadow[a3] = d[31:24];
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_last  = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},    32'(bus.gnt_o),    32'd0);
    check({tag, "_rvalid"}, 32'(bus.rvalid_o), 32'd0);
    check({tag, "_rdata"},  bus.rdata_o,       32'd0);
    check({tag, "_err"},    32'(bus.err_o),    32'd0);
    check({tag, "_wen"},    32'(wen),          32'd0);
    check({tag, "_a"},      32'(a),            32'd0);
    check({tag, "_wd"},     wd,                32'd0);
    check({tag, "_load3"},  32'(t),            32'(WORD));
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic step();
    logic [1:0] e_gnt, e_rv;
    logic       win;
    @(negedge clk);
    bus.req_i    = s_req;
    bus.rready_i = s_rr;
    for (int p = 0; p < 2; p++) begin
      bus.addr_i[p]  = s_addr[p];
      bus.wdata_i[p] = s_wd[p];
      bus.load3_i[p] = s_ty[p];
      bus.we_i[p]    = s_we[p];
    end
    #1;
    e_gnt = 2'b00;
    e_rv  = 2'b00;
    win   = 1'b0;
    if (m_phase == 0 && s_req != 2'b00) begin
      win = (s_req == 2'b11) ? !m_last : s_req[1];
      e_gnt[win] = 1'b1;
    end
    if (m_phase == 2) e_rv[m_owner] = 1'b1;
    check("gnt",    32'(bus.gnt_o),    32'(e_gnt));
    check("rvalid", 32'(bus.rvalid_o), 32'(e_rv));
    check("wen",    32'(wen),          32'(m_phase == 1 && m_we && !m_err));
    if (m_phase == 1) begin
      check("a",     32'(a), 32'(m_addr));
      check("load3", 32'(t), 32'(m_ty));
      if (m_we) check("wd", wd, m_wd);
    end
    if (m_phase == 2) begin
      check("rdata", bus.rdata_o,     m_rdata);
      check("err",   32'(bus.err_o),  32'(m_err));
      if (s_rr[m_owner]) begin
        last_rdata = bus.rdata_o;
        last_err   = bus.err_o;
      end
    end
    granted = e_gnt;
    if (e_gnt != 2'b00) gnt_log.push_back(int'(win));
    @(posedge clk);
    case (m_phase)
      0: if (e_gnt != 2'b00) begin
        m_owner = win;
        m_last  = win;
        m_addr  = s_addr[win];
        m_wd    = s_wd[win];
        m_ty    = s_ty[win];
        m_we    = s_we[win];
        m_err   = spec_err(m_addr, m_ty, m_we);
        m_rdata = (m_we || m_err) ? 32'd0 : read_bytes(shadow, m_addr, m_ty);
        if (m_we && !m_err) shadow_store(m_addr, m_ty, m_wd);
        m_phase = 1;
      end
      1: m_phase = 2;
      default: if (s_rr[m_owner]) m_phase = 0;
    endcase
  endtask

  task automatic run_until_idle();
    int n = 0;
    while ((m_phase != 0 || s_req != 2'b00) && n < 60) begin
      step();
      s_req = s_req & ~granted;
      n++;
    end
    if (n >= 60) check("idle_timeout", 32'(m_phase), 32'd0);
  endtask

  task automatic set_port(input int p, input logic [7:0] ad, input load3_t ty, input logic we, input logic [31:0] d);
    s_addr[p] = ad;
    s_ty[p]   = ty;
    s_we[p]   = we;
    s_wd[p]   = d;
    s_req[p]  = 1'b1;
  endtask

  task automatic xact(input int p, input logic [7:0] ad, input load3_t ty, input logic we, input logic [31:0] d);
    set_port(p, ad, ty, we, d);
    s_rr = 2'b11;
    run_until_idle();
  endtask

  load3_t types [5] = '{BYTE, HALF, WORD, U_BYTE, U_HALF};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_req = 2'b00;
    s_rr  = 2'b11;
    for (int p = 0; p < 2; p++) begin
      s_addr[p] = 8'd0;
      s_wd[p]   = 32'd0;
      s_ty[p]   = WORD;
      s_we[p]   = 1'b0;
    end
    bus.req_i    = 2'b00;
    bus.rready_i = 2'b11;
    bus.addr_i   = '0;
    bus.wdata_i  = '0;
    bus.load3_i  = {WORD, WORD};
    bus.we_i     = 2'b00;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    model_reset();
    last_rdata = 32'd0;
    last_err   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Store then load a word through port 0.
    xact(0, 8'h10, WORD, 1'b1, 32'hDEADBEEF);
    xact(0, 8'h10, WORD, 1'b0, 32'd0);
    check("ld_deadbeef", last_rdata, 32'hDEADBEEF);
    check("ld_deadbeef_err", 32'(last_err), 32'd0);

    // Simultaneous loads: grants must alternate between ports.
    gnt_log.delete();
    for (int r = 0; r < 4; r++) begin
      set_port(0, 8'(8 * r), WORD, 1'b0, 32'd0);
      set_port(1, 8'(8 * r + 4), WORD, 1'b0, 32'd0);
      s_rr = 2'b11;
      run_until_idle();
    end
    check("alt_count", 32'(gnt_log.size()), 32'd8);
    for (int i = 1; i < gnt_log.size(); i++)
      check("alt_order", 32'(gnt_log[i]), 32'(1 - gnt_log[i-1]));

    // Misaligned half store must not reach memory.
    xact(0, 8'h11, HALF, 1'b1, 32'h00001234);
    check("half_err", 32'(last_err), 32'd1);
    xact(0, 8'h10, WORD, 1'b0, 32'd0);
    check("ld_after_err", last_rdata, 32'hDEADBEEF);
    xact(1, 8'h30, load3_t'(3'd7), 1'b1, 32'h55AA55AA);
    check("undef_err", 32'(last_err), 32'd1);

    // Sign and zero extension of a byte.
    xact(0, 8'h20, BYTE, 1'b1, 32'h00000080);
    xact(1, 8'h20, BYTE, 1'b0, 32'd0);
    check("ld_byte", last_rdata, 32'hFFFFFF80);
    xact(1, 8'h20, U_BYTE, 1'b0, 32'd0);
    check("ld_ubyte", last_rdata, 32'h00000080);

    // Port 1 stalls its response while port 0 keeps requesting.
    set_port(1, 8'h10, WORD, 1'b0, 32'd0);
    s_rr = 2'b11;
    step();
    s_req = s_req & ~granted;
    set_port(0, 8'h20, U_BYTE, 1'b0, 32'd0);
    s_rr = 2'b01;
    repeat (6) step();
    s_rr = 2'b11;
    gnt_log.delete();
    step();
    step();
    check("stall_next_gnt", 32'(gnt_log.size()), 32'd1);
    s_req = s_req & ~granted;
    run_until_idle();

    // Asynchronous reset while a store is at the memory.
    set_port(0, 8'hF0, WORD, 1'b1, 32'h12345678);
    s_rr = 2'b11;
    step();
    s_req = 2'b00;
    @(negedge clk);
    bus.req_i = 2'b00;
    #1;
    check("pre_rst_wen", 32'(wen), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_access");
    #1;
    rst_n = 1'b1;
    model_reset();

    // Asynchronous reset while a response is pending.
    set_port(1, 8'h10, WORD, 1'b0, 32'd0);
    s_rr = 2'b11;
    step();
    s_req = 2'b00;
    step();
    @(negedge clk);
    bus.req_i    = 2'b00;
    bus.rready_i = 2'b00;
    #1;
    check("pre_rst_rvalid", 32'(bus.rvalid_o), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_resp");
    #1;
    rst_n = 1'b1;
    model_reset();

    // Random traffic on both ports.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!s_req[p] && ($urandom % 3) == 0)
          set_port(p, 8'($urandom_range(0, 63)), types[$urandom % 5], 1'($urandom % 2), $urandom);
        else if (s_req[p] && ($urandom % 16) == 0)
          s_req[p] = 1'b0;
      end
      s_rr = 2'($urandom);
      step();
      s_req = s_req & ~granted;
    end
    s_req = 2'b00;
    s_rr  = 2'b11;
    run_until_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
